// File: rtl/mesh_traffic_ctrl_if.sv
// ---------------------------------------------------------------------------
// mesh_traffic_ctrl_if
// Bundle between a host/bench and the mesh traffic-pattern sequencer.
//   master modport : host side; drives start/pattern_sel/rate_sel and the
//                    mesh finish flags, observes configuration and status.
//   slave modport  : sequencer side (mesh_traffic_ctrl).
// Signals:
//   start, pattern_sel[2:0], rate_sel[3:0]          run request
//   pe_task_receive/send_finish_flag[7:0]           per-PE finish flags
//   pe_enable, pe_dbg_mode_wire, pe_flush_wire [7:0] per-PE controls
//   pe_send_num_wire, pe_receive_num_wire [23:0]    3 bits per PE
//   pe_rate_wire, pe_mode_wire [31:0]               4 bits per PE
//   pe_dst_seq_wire [191:0]                         24 bits per PE
//   busy, done, timeout, cycle_count[CNT_W-1:0]     status
// ---------------------------------------------------------------------------
interface mesh_traffic_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             start;
   logic [2:0]       pattern_sel;
   logic [3:0]       rate_sel;
   logic [7:0]       pe_task_receive_finish_flag;
   logic [7:0]       pe_task_send_finish_flag;
   logic [7:0]       pe_enable;
   logic [7:0]       pe_dbg_mode_wire;
   logic [23:0]      pe_send_num_wire;
   logic [23:0]      pe_receive_num_wire;
   logic [31:0]      pe_rate_wire;
   logic [191:0]     pe_dst_seq_wire;
   logic [31:0]      pe_mode_wire;
   logic [7:0]       pe_flush_wire;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output start, pattern_sel, rate_sel,
             pe_task_receive_finish_flag, pe_task_send_finish_flag,
      input  pe_enable, pe_dbg_mode_wire, pe_send_num_wire, pe_receive_num_wire,
             pe_rate_wire, pe_dst_seq_wire, pe_mode_wire, pe_flush_wire,
             busy, done, timeout, cycle_count
   );

   modport slave (
      input  start, pattern_sel, rate_sel,
             pe_task_receive_finish_flag, pe_task_send_finish_flag,
      output pe_enable, pe_dbg_mode_wire, pe_send_num_wire, pe_receive_num_wire,
             pe_rate_wire, pe_dst_seq_wire, pe_mode_wire, pe_flush_wire,
             busy, done, timeout, cycle_count
   );
endinterface

// File: rtl/mesh_traffic_ctrl.sv
// ---------------------------------------------------------------------------
// mesh_traffic_ctrl
// Traffic-pattern sequencer for the 2x4 mesh. On an accepted start it latches
// one of eight canonical patterns into the per-PE configuration buses, then
// walks FLUSH -> SETTLE -> RUN, and in RUN waits for the required per-PE
// finish flags, reporting the run length in cycle_count.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : mesh_traffic_ctrl_if.slave (request, mesh config, flags, status)
// ---------------------------------------------------------------------------
module mesh_traffic_ctrl #(
   parameter int FLUSH_CYCLES   = 4,
   parameter int SETTLE_CYCLES  = 50,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 32
) (
   input logic                clk,
   input logic                rst_n,
   mesh_traffic_ctrl_if.slave bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FLUSH  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;
   localparam logic [1:0] ST_RUN    = 2'd3;

   localparam logic [2:0] PAT_HOTSPOT = 3'd6;

   // Phase counter counts down from N-1 to 0, so it only has to hold N-1.
   localparam int PH_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
   localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
   localparam logic [PH_W-1:0]  FLUSH_LOAD    = PH_W'(FLUSH_CYCLES - 1);
   localparam logic [PH_W-1:0]  SETTLE_LOAD   = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [1:0]       state_reg;
   logic [PH_W-1:0]  phase_reg;
   logic [CNT_W-1:0] cycle_count_reg;
   logic [CNT_W-1:0] cycle_count_inc;
   logic             done_reg;
   logic             timeout_reg;
   logic             hotspot_reg;

   logic [23:0]      send_num_reg,  send_num_next;
   logic [23:0]      recv_num_reg,  recv_num_next;
   logic [191:0]     dst_seq_reg,   dst_seq_next;
   logic [31:0]      mode_reg,      mode_next;
   logic [31:0]      rate_reg;

   logic [7:0]       send_req;
   logic [7:0]       recv_req;
   logic             run_complete;

   // Per-PE configuration decoded from the live pattern_sel; only captured
   // into the *_reg copies on an accepted start.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_pe
         localparam logic [2:0] IDX = 3'(gi);
         logic [2:0] dst;
         logic [2:0] send_n;
         logic [2:0] recv_n;
         logic [3:0] mode_n;

         always_comb begin
            dst    = 3'd0;
            send_n = 3'd1;
            recv_n = 3'd1;
            mode_n = 4'b0001;
            case (bus.pattern_sel)
               3'd0: dst = ~IDX;                       // complement: 7-i
               3'd1: dst = {IDX[0], IDX[1], IDX[2]};   // bit reverse
               3'd2: dst = {IDX[0], IDX[2:1]};         // rotate right
               3'd3: dst = {IDX[1:0], IDX[2]};         // rotate left
               3'd4: dst = IDX + 3'd3;                 // tornado
               3'd5: dst = IDX + 3'd1;                 // neighbor
               3'd6: begin                             // hotspot: all send to PE0
                  send_n = (IDX == 3'd0) ? 3'd0 : 3'd1;
                  recv_n = (IDX == 3'd0) ? 3'd7 : 3'd0;
               end
               default: begin                          // turn
                  send_n = 3'd7;
                  recv_n = 3'd7;
                  mode_n = 4'b0000;
               end
            endcase
         end

         assign send_num_next[3*gi +: 3]  = send_n;
         assign recv_num_next[3*gi +: 3]  = recv_n;
         assign mode_next[4*gi +: 4]      = mode_n;
         assign dst_seq_next[24*gi +: 24] = {21'd0, dst};

         // A PE's flag only matters when it has something to send/receive.
         assign send_req[gi] = |send_num_reg[3*gi +: 3];
         assign recv_req[gi] = |recv_num_reg[3*gi +: 3];
      end
   endgenerate

   assign run_complete = (&(bus.pe_task_send_finish_flag | ~send_req)) &
                         (&(bus.pe_task_receive_finish_flag | ~recv_req));

   assign cycle_count_inc = (&cycle_count_reg) ? cycle_count_reg
                                               : cycle_count_reg + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         phase_reg       <= '0;
         cycle_count_reg <= '0;
         done_reg        <= 1'b0;
         timeout_reg     <= 1'b0;
         hotspot_reg     <= 1'b0;
         send_num_reg    <= '0;
         recv_num_reg    <= '0;
         dst_seq_reg     <= '0;
         mode_reg        <= '0;
         rate_reg        <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  send_num_reg    <= send_num_next;
                  recv_num_reg    <= recv_num_next;
                  dst_seq_reg     <= dst_seq_next;
                  mode_reg        <= mode_next;
                  rate_reg        <= {8{bus.rate_sel}};
                  hotspot_reg     <= (bus.pattern_sel == PAT_HOTSPOT);
                  timeout_reg     <= 1'b0;
                  cycle_count_reg <= '0;
                  phase_reg       <= FLUSH_LOAD;
                  state_reg       <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (phase_reg == '0) begin
                  phase_reg <= SETTLE_LOAD;
                  state_reg <= ST_SETTLE;
               end else begin
                  phase_reg <= phase_reg - PH_W'(1);
               end
            end
            ST_SETTLE: begin
               if (phase_reg == '0) begin
                  state_reg <= ST_RUN;
               end else begin
                  phase_reg <= phase_reg - PH_W'(1);
               end
            end
            default: begin // ST_RUN
               cycle_count_reg <= cycle_count_inc;
               // Completion is checked first so it wins over a coincident timeout.
               if (run_complete) begin
                  done_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
               end else if (cycle_count_inc >= TIMEOUT_LIMIT) begin
                  timeout_reg <= 1'b1;
                  state_reg   <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Flush is high in IDLE and FLUSH, except a hotspot run keeps it low from
   // its start until the next start.
   always_comb begin
      bus.pe_flush_wire = 8'h00;
      if ((state_reg == ST_IDLE) || (state_reg == ST_FLUSH)) begin
         bus.pe_flush_wire = hotspot_reg ? 8'h00 : 8'hFF;
      end
   end

   assign bus.pe_enable           = (state_reg == ST_RUN) ? 8'hFF : 8'h00;
   assign bus.pe_dbg_mode_wire    = 8'hFF;
   assign bus.pe_send_num_wire    = send_num_reg;
   assign bus.pe_receive_num_wire = recv_num_reg;
   assign bus.pe_rate_wire        = rate_reg;
   assign bus.pe_dst_seq_wire     = dst_seq_reg;
   assign bus.pe_mode_wire        = mode_reg;
   assign bus.busy                = (state_reg != ST_IDLE);
   assign bus.done                = done_reg;
   assign bus.timeout             = timeout_reg;
   assign bus.cycle_count         = cycle_count_reg;

endmodule

// File: tb/tb_mesh_traffic_ctrl.sv
module tb_mesh_traffic_ctrl;
   localparam int CNT_W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mesh_traffic_ctrl_if #(.CNT_W(CNT_W)) bus ();

   mesh_traffic_ctrl #(
      .FLUSH_CYCLES(4),
      .SETTLE_CYCLES(50),
      .TIMEOUT_CYCLES(4096),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [2:0]  pat;
      logic [3:0]  rate;
      int          flag_at;     // RUN cycle flags rise; 0 = already high, -1 = never
      logic [7:0]  send_flags;
      logic [7:0]  recv_flags;
      logic        stray_start;
      logic [23:0] exp_dst;     // 3-bit destination per PE, PE7..PE0
      logic [23:0] exp_send;
      logic [23:0] exp_recv;
      logic [31:0] exp_mode;
      logic        exp_hot;
      logic        exp_done;
      logic        exp_timeout;
      int          exp_count;
   } vec_t;

   typedef struct {
      int   tag;
      logic done;
      logic timeout;
      int   count;
   } sb_t;

   sb_t  sb_q[$];
   vec_t vecs[9];
   int   compared   = 0;
   int   mismatched = 0;

   function automatic vec_t mk(input logic [2:0] pat, input logic [3:0] rate, input int flag_at,
                               input logic [7:0] sf, input logic [7:0] rf, input logic stray,
                               input logic [23:0] dst, input logic [23:0] snd, input logic [23:0] rcv,
                               input logic [31:0] mode, input logic hot, input logic dn,
                               input logic to, input int cnt);
      vec_t v;
      v.pat = pat; v.rate = rate; v.flag_at = flag_at; v.send_flags = sf; v.recv_flags = rf;
      v.stray_start = stray; v.exp_dst = dst; v.exp_send = snd; v.exp_recv = rcv;
      v.exp_mode = mode; v.exp_hot = hot; v.exp_done = dn; v.exp_timeout = to; v.exp_count = cnt;
      return v;
   endfunction

   function automatic logic [191:0] expand_dst(input logic [23:0] d);
      logic [191:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[24*i +: 3] = d[3*i +: 3];
      return r;
   endfunction

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "/enable"},  bus.pe_enable, 8'h00);
      check({tag, "/dbg"},     bus.pe_dbg_mode_wire, 8'hFF);
      check({tag, "/flush"},   bus.pe_flush_wire, 8'hFF);
      check({tag, "/send"},    bus.pe_send_num_wire, 24'h0);
      check({tag, "/recv"},    bus.pe_receive_num_wire, 24'h0);
      check({tag, "/rate"},    bus.pe_rate_wire, 32'h0);
      check({tag, "/dst"},     bus.pe_dst_seq_wire, 192'h0);
      check({tag, "/mode"},    bus.pe_mode_wire, 32'h0);
      check({tag, "/busy"},    bus.busy, 1'b0);
      check({tag, "/done"},    bus.done, 1'b0);
      check({tag, "/timeout"}, bus.timeout, 1'b0);
      check({tag, "/count"},   bus.cycle_count, 32'h0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      sb_t e;
      int  pre;
      int  hi;
      int  n;
      @(negedge clk);
      bus.pattern_sel = v.pat;
      bus.rate_sel    = v.rate;
      bus.start       = 1'b1;
      if (v.flag_at == 0) begin
         bus.pe_task_send_finish_flag    = v.send_flags;
         bus.pe_task_receive_finish_flag = v.recv_flags;
      end
      e.tag = idx; e.done = v.exp_done; e.timeout = v.exp_timeout; e.count = v.exp_count;
      sb_q.push_back(e);
      @(negedge clk);
      // Scramble the selectors: the latched configuration must not follow them.
      bus.start       = 1'b0;
      bus.pattern_sel = ~v.pat;
      bus.rate_sel    = ~v.rate;
      check("start/busy",    bus.busy, 1'b1);
      check("start/timeout", bus.timeout, 1'b0);
      check("start/count",   bus.cycle_count, 32'h0);
      check("cfg/dst",       bus.pe_dst_seq_wire, expand_dst(v.exp_dst));
      check("cfg/send",      bus.pe_send_num_wire, v.exp_send);
      check("cfg/recv",      bus.pe_receive_num_wire, v.exp_recv);
      check("cfg/mode",      bus.pe_mode_wire, v.exp_mode);
      check("cfg/rate",      bus.pe_rate_wire, {8{v.rate}});
      pre = 0;
      hi  = 0;
      while (bus.pe_enable == 8'h00 && pre < 200) begin
         pre++;
         if (bus.pe_flush_wire == 8'hFF) hi++;
         else if (bus.pe_flush_wire != 8'h00) hi += 1000;
         @(negedge clk);
      end
      check("prerun_cycles", pre, 54);
      check("flush_high_cycles", hi, v.exp_hot ? 0 : 4);
      n = 0;
      while (bus.pe_enable == 8'hFF && n < 5000) begin
         n++;
         if (n == v.flag_at) begin
            bus.pe_task_send_finish_flag    = v.send_flags;
            bus.pe_task_receive_finish_flag = v.recv_flags;
         end
         bus.start = v.stray_start && (n == 2);
         if (v.stray_start && n == 2) bus.pattern_sel = 3'd7;
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("run_enable_cycles", n, v.exp_count);
      if (sb_q.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL scoreboard: actual empty required entry");
      end else begin
         e = sb_q.pop_front();
         check("end/done",    bus.done, e.done);
         check("end/timeout", bus.timeout, e.timeout);
         check("end/count",   bus.cycle_count, e.count);
      end
      check("end/enable", bus.pe_enable, 8'h00);
      check("end/busy",   bus.busy, 1'b0);
      check("end/flush",  bus.pe_flush_wire, v.exp_hot ? 8'h00 : 8'hFF);
      check("end/dst",    bus.pe_dst_seq_wire, expand_dst(v.exp_dst));
      $display("run %0d pattern %0d rate %0d: cycles %0d done %0b timeout %0b count %0d",
               idx, v.pat, v.rate, n, bus.done, bus.timeout, bus.cycle_count);
      bus.pe_task_send_finish_flag    = 8'h00;
      bus.pe_task_receive_finish_flag = 8'h00;
      @(negedge clk);
      check("after/done",    bus.done, 1'b0);
      check("after/timeout", bus.timeout, v.exp_timeout);
      check("after/busy",    bus.busy, 1'b0);
      check("after/flush",   bus.pe_flush_wire, v.exp_hot ? 8'h00 : 8'hFF);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual simulation still running required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      bus.start = 1'b0;
      bus.pattern_sel = 3'd0;
      bus.rate_sel = 4'd0;
      bus.pe_task_send_finish_flag = 8'h00;
      bus.pe_task_receive_finish_flag = 8'h00;

      vecs[0] = mk(3'd0, 4'd0,  30, 8'hFF, 8'hFF, 1'b0, 24'o01234567, 24'o11111111, 24'o11111111, 32'h11111111, 1'b0, 1'b1, 1'b0, 30);
      vecs[1] = mk(3'd1, 4'd5,   3, 8'hFF, 8'hFF, 1'b0, 24'o73516240, 24'o11111111, 24'o11111111, 32'h11111111, 1'b0, 1'b1, 1'b0, 3);
      vecs[2] = mk(3'd2, 4'd9,   0, 8'hFF, 8'hFF, 1'b0, 24'o73625140, 24'o11111111, 24'o11111111, 32'h11111111, 1'b0, 1'b1, 1'b0, 1);
      vecs[3] = mk(3'd3, 4'd15,  7, 8'hFF, 8'hFF, 1'b0, 24'o75316420, 24'o11111111, 24'o11111111, 32'h11111111, 1'b0, 1'b1, 1'b0, 7);
      vecs[4] = mk(3'd4, 4'd2,  12, 8'hFF, 8'hFF, 1'b1, 24'o21076543, 24'o11111111, 24'o11111111, 32'h11111111, 1'b0, 1'b1, 1'b0, 12);
      vecs[5] = mk(3'd5, 4'd3,   5, 8'hFF, 8'hFF, 1'b0, 24'o07654321, 24'o11111111, 24'o11111111, 32'h11111111, 1'b0, 1'b1, 1'b0, 5);
      vecs[6] = mk(3'd6, 4'd1,  10, 8'hFE, 8'h01, 1'b0, 24'o00000000, 24'o11111110, 24'o00000007, 32'h11111111, 1'b1, 1'b1, 1'b0, 10);
      vecs[7] = mk(3'd7, 4'd6,  -1, 8'hFF, 8'hFF, 1'b0, 24'o00000000, 24'o77777777, 24'o77777777, 32'h00000000, 1'b0, 1'b0, 1'b1, 4096);
      vecs[8] = mk(3'd0, 4'd7,   2, 8'hFF, 8'hFF, 1'b0, 24'o01234567, 24'o11111111, 24'o11111111, 32'h11111111, 1'b0, 1'b1, 1'b0, 2);

      repeat (3) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset("idle");

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      bus.pattern_sel = 3'd0;
      bus.rate_sel    = 4'd4;
      bus.start       = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      w = 0;
      while (bus.pe_enable != 8'hFF && w < 200) begin
         w++;
         @(negedge clk);
      end
      check("midrun/reached_run", bus.pe_enable, 8'hFF);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("midrun");
      repeat (2) @(negedge clk);
      check_reset("held");
      rst_n = 1'b1;
      $display("reset applied mid-run: busy %0b enable %0h", bus.busy, bus.pe_enable);
      run_vec(vecs[5], 9);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
